// File: rtl/flop_pkg.sv
// flop_pkg: shared FP16 accumulate types
// Operand layout, widths and FSM encoding
package flop_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int GRD_W = 3;
  localparam int BIAS  = 15;

  localparam logic [14:0] MAX_MAG = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } operand_t;

endpackage

// File: rtl/flop_lzc.sv
// flop_lzc: leading-zero counter
// All-zero input reports W
module flop_lzc #(
  parameter int W  = 14,
  parameter int CW = 4
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // highest set bit wins; scanning upward lets it overwrite
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/flop_acc.sv
// flop_acc: sequential FP16 accumulator
// align / add / normalize, truncating
module flop_acc #(
  parameter int EXP_W = flop_pkg::EXP_W,
  parameter int MAN_W = flop_pkg::MAN_W,
  parameter int GRD_W = flop_pkg::GRD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   acc_clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W-1:0]       in_man,
  output logic [EXP_W+MAN_W:0]   acc_out,
  output logic                   sum_valid,
  output logic                   ovf
);

  import flop_pkg::*;

  localparam int SIG_W = MAN_W + GRD_W + 1;
  localparam int SUM_W = SIG_W + 1;
  localparam int MAG_W = EXP_W + MAN_W;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam int XW    = EXP_W + 2;

  localparam logic signed [XW-1:0] EXP_TOP =
    XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  state_t           state;
  operand_t         op_q;
  logic             big_sign_q;
  logic             sub_q;
  logic [EXP_W-1:0] big_exp_q;
  logic [SIG_W-1:0] big_sig_q;
  logic [SIG_W-1:0] sml_sig_q;
  logic [SUM_W-1:0] sum_q;

  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_man;
  logic [MAG_W-1:0] a_key;
  logic [MAG_W-1:0] b_key;
  logic             b_big;

  logic             l_sign;
  logic [EXP_W-1:0] l_exp;
  logic [EXP_W-1:0] s_exp;
  logic [EXP_W-1:0] shamt;
  logic [SIG_W-1:0] l_sig;
  logic [SIG_W-1:0] s_sig;
  logic [SIG_W-1:0] s_aln;

  logic [CNT_W-1:0]       lz;
  logic [MAN_W-1:0]       n_man;
  logic signed [XW-1:0]   n_exp;

  function automatic logic [SIG_W-1:0] sig_of(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    return (e == '0) ? '0 : {1'b1, m, {GRD_W{1'b0}}};
  endfunction

  assign in_ready = (state == IDLE) && !acc_clr;

  assign {a_sign, a_exp, a_man} = acc_out;

  // zero compares below every normal value
  assign a_key = (a_exp == '0) ? '0 : {a_exp, a_man};
  assign b_key = (op_q.exp == '0) ? '0
               : {op_q.exp, op_q.man};
  assign b_big = b_key > a_key;

  // order by magnitude and align the smaller
  always_comb begin
    if (b_big) begin
      l_sign = op_q.sign;
      l_exp  = op_q.exp;
      l_sig  = sig_of(op_q.exp, op_q.man);
      s_exp  = a_exp;
      s_sig  = sig_of(a_exp, a_man);
    end else begin
      l_sign = a_sign;
      l_exp  = a_exp;
      l_sig  = sig_of(a_exp, a_man);
      s_exp  = op_q.exp;
      s_sig  = sig_of(op_q.exp, op_q.man);
    end
    shamt = l_exp - s_exp;
    s_aln = (int'(shamt) >= SIG_W) ? '0
          : s_sig >> shamt;
  end

  flop_lzc #(
    .W  (SIG_W),
    .CW (CNT_W)
  ) u_lzc (
    .din (sum_q[SIG_W-1:0]),
    .cnt (lz)
  );

  // renormalise; the fraction drops hidden and guard bits
  always_comb begin
    if (sum_q[SUM_W-1]) begin
      n_man = MAN_W'(sum_q >> (GRD_W + 1));
      n_exp = XW'(big_exp_q) + EXP_ONE;
    end else begin
      n_man = MAN_W'((sum_q[SIG_W-1:0] << lz) >> GRD_W);
      n_exp = XW'(big_exp_q) - XW'(lz);
    end
  end

  // control FSM plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_out    <= '0;
      sum_valid  <= 1'b0;
      ovf        <= 1'b0;
      op_q       <= '0;
      big_sign_q <= 1'b0;
      sub_q      <= 1'b0;
      big_exp_q  <= '0;
      big_sig_q  <= '0;
      sml_sig_q  <= '0;
      sum_q      <= '0;
    end else begin
      sum_valid <= 1'b0;
      if (acc_clr) begin
        state   <= IDLE;
        acc_out <= '0;
        ovf     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid) begin
              op_q  <= '{sign: in_sign,
                         exp:  in_exp,
                         man:  in_man};
              state <= ALIGN;
            end
          end
          ALIGN: begin
            big_sign_q <= l_sign;
            big_exp_q  <= l_exp;
            big_sig_q  <= l_sig;
            sml_sig_q  <= s_aln;
            sub_q      <= op_q.sign ^ a_sign;
            state      <= ADD;
          end
          ADD: begin
            sum_q <= sub_q
              ? {1'b0, big_sig_q} - {1'b0, sml_sig_q}
              : {1'b0, big_sig_q} + {1'b0, sml_sig_q};
            state <= NORM;
          end
          NORM: begin
            state     <= IDLE;
            sum_valid <= 1'b1;
            if (sum_q == '0) begin
              acc_out <= '0;
            end else if (n_exp > EXP_TOP) begin
              acc_out <= {big_sign_q, MAX_MAG};
              ovf     <= 1'b1;
            end else if (n_exp < EXP_ONE) begin
              acc_out <= '0;
            end else begin
              acc_out <= {big_sign_q,
                          n_exp[EXP_W-1:0],
                          n_man};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flop_acc.sv
// tb_flop_acc: random + directed bench
// integer-scaled reference accumulator
module tb_flop_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_clr;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [9:0]  in_man;
  logic [15:0] acc_out;
  logic        sum_valid;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_acc;
  logic        m_ovf;

  always #5 clk = ~clk;

  flop_acc dut (
    .clk       (clk),
    .rst       (rst),
    .acc_clr   (acc_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .acc_out   (acc_out),
    .sum_valid (sum_valid),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h @%0t",
                  tag, got, want, $time);
  endtask

  // Values scaled so a normal with exponent e is
  // (1024+man)*8 * 2^(e-1): the larger operand's
  // guard LSB is 2^(le-1); the smaller is floored
  // to that grid, then the exact sum is truncated.
  function automatic logic [16:0] ref_add(
    input logic [15:0] a,
    input logic        bs,
    input logic [4:0]  be,
    input logic [9:0]  bm
  );
    longint ma, mb, big, sml, r, man;
    logic   sbig, ssml;
    int     le, p, e;
    ma = (a[14:10] == 0) ? 64'd0
       : longint'(1024 + a[9:0]) << (a[14:10] + 2);
    mb = (be == 0) ? 64'd0
       : longint'(1024 + bm) << (be + 2);
    if (mb > ma) begin
      big = mb; sml = ma; sbig = bs;
      ssml = a[15]; le = int'(be);
    end else begin
      big = ma; sml = mb; sbig = a[15];
      ssml = bs; le = int'(a[14:10]);
    end
    if (big == 0) return 17'h0;
    sml = (sml >> (le - 1)) << (le - 1);
    r = (sbig == ssml) ? big + sml : big - sml;
    if (r == 0) return 17'h0;
    p = 0;
    for (int i = 0; i < 63; i++) if (r[i]) p = i;
    e = p - 12;
    if (e > 31) return {1'b1, sbig, 15'h7FFF};
    if (e < 1) return 17'h0;
    man = (r >> (e + 2)) - 1024;
    return {1'b0, sbig, e[4:0], man[9:0]};
  endfunction

  task automatic model_step(input logic s,
                            input logic [4:0] e,
                            input logic [9:0] m);
    logic [16:0] r;
    r = ref_add(m_acc, s, e, m);
    m_acc = r[15:0];
    m_ovf = m_ovf | r[16];
  endtask

  // starts and ends on a falling edge with DUT idle
  task automatic op_run(input logic s,
                        input logic [4:0] e,
                        input logic [9:0] m);
    chk("rdy0", in_ready, 1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_step(s, e, m);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy", in_ready, 0);
      chk("early_sv", sum_valid, 0);
    end
    @(negedge clk);
    chk("sv", sum_valid, 1);
    chk("sum", acc_out, m_acc);
    chk("ovf", ovf, m_ovf);
    chk("rdy4", in_ready, 1);
  endtask

  task automatic do_clr();
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    @(negedge clk);
    chk("clr_acc", acc_out, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_sv", sum_valid, 0);
    m_acc = '0;
    m_ovf = 1'b0;
  endtask

  initial begin
    logic [4:0]  pe[4];
    logic [9:0]  pm[4];
    logic        ps[4];
    int          acc_cyc[4];
    int          k;
    logic [15:0] expq[$];
    int          sel;
    logic        rs;
    logic [4:0]  re;
    logic [9:0]  rm;

    rst = 1'b1; acc_clr = 1'b0; in_valid = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_man = '0;
    m_acc = '0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc_out, 0);
    chk("rst_sv", sum_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rdy", in_ready, 1);

    op_run(0, 15, 0);
    chk("one", acc_out, 16'h3C00);
    op_run(0, 15, 0);
    chk("two", acc_out, 16'h4000);

    do_clr();
    op_run(0, 15, 10'h200);
    op_run(1, 15, 10'h200);
    chk("cancel", acc_out, 16'h0000);

    do_clr();
    op_run(0, 25, 0);
    op_run(0, 15, 0);
    chk("align", acc_out, 16'h6401);

    do_clr();
    op_run(0, 30, 0);
    op_run(0, 15, 0);
    chk("discard", acc_out, 16'h7800);

    do_clr();
    op_run(0, 31, 10'h3FF);
    op_run(0, 31, 10'h3FF);
    chk("sat", acc_out, 16'h7FFF);
    chk("sat_ovf", ovf, 1);
    op_run(1, 31, 10'h3FF);
    chk("ovf_sticky", ovf, 1);
    do_clr();

    // clear during ADD aborts the operation
    op_run(0, 15, 0);
    in_valid = 1'b1;
    in_sign = 1'b0; in_exp = 5'd15; in_man = '0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    chk("ab_rdy", in_ready, 1);
    chk("ab_acc", acc_out, 0);
    chk("ab_sv", sum_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_nosv", sum_valid, 0);
    end

    // clear beats a simultaneous product in IDLE
    acc_clr = 1'b1;
    in_valid = 1'b1;
    in_sign = 1'b0; in_exp = 5'd15; in_man = '0;
    #1 chk("cv_rdy", in_ready, 0);
    @(posedge clk);
    #1 acc_clr = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cv_idle", in_ready, 1);
      chk("cv_nosv", sum_valid, 0);
    end
    chk("cv_acc", acc_out, 0);

    // back-to-back with in_valid held high
    ps[0] = 0; pe[0] = 15; pm[0] = 0;
    ps[1] = 0; pe[1] = 16; pm[1] = 10'h100;
    ps[2] = 1; pe[2] = 14; pm[2] = 10'h3FF;
    ps[3] = 0; pe[3] = 20; pm[3] = 10'h005;
    for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      if (sum_valid) begin
        if (expq.size() == 0) chk("bb_extra", 1, 0);
        else chk("bb_sum", acc_out, expq.pop_front());
      end
      if (k < 4) begin
        in_valid = 1'b1;
        in_sign = ps[k]; in_exp = pe[k]; in_man = pm[k];
        if (in_ready) begin
          acc_cyc[k] = c;
          model_step(ps[k], pe[k], pm[k]);
          expq.push_back(m_acc);
          k++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("bb_cnt", k, 4);
    chk("bb_drain", expq.size(), 0);
    for (int i = 0; i < 4; i++)
      chk("bb_cyc", acc_cyc[i], 4 * i);

    // reset mid-operation with ovf set
    op_run(0, 31, 10'h3FF);
    op_run(0, 31, 10'h3FF);
    in_valid = 1'b1;
    in_sign = 1'b0; in_exp = 5'd15; in_man = '0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);
    chk("mr_acc", acc_out, 0);
    chk("mr_ovf", ovf, 0);
    chk("mr_sv", sum_valid, 0);
    chk("mr_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_nosv", sum_valid, 0);
    end

    // randomized accumulation
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_clr();
      end else begin
        sel = $urandom_range(0, 7);
        rs = 1'($urandom);
        rm = 10'($urandom);
        if (sel == 0) begin
          rs = ~m_acc[15];
          re = m_acc[14:10];
          rm = m_acc[9:0];
        end else if (sel == 1) begin
          re = '0;
        end else if (sel < 5) begin
          re = 5'($urandom_range(10, 20));
        end else begin
          re = 5'($urandom_range(1, 31));
        end
        op_run(rs, re, rm);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
